// File: rtl/simd_core_port.sv
// Per-core RAM request port: holds one load/store on the arbiter lane until grant, waits out read latency.
// Latency: store done 1 cycle after grant edge; load done 1 cycle after grant+RD_LAT edge; done pulses 1 cycle.
// Backpressure: core_ready is low from acceptance until IDLE; starved lanes abort after TIMEOUT REQ edges.
module simd_core_port #(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       core_req,
    input  logic       core_we,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_ready,
    output logic       core_done,
    output logic       core_err,
    output logic [7:0] core_rdata,
    output logic       arb_rden,
    output logic       arb_wren,
    output logic [7:0] arb_addr,
    output logic [7:0] arb_din,
    input  logic       arb_acq,
    input  logic [7:0] arb_dq
);

    typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} state_t;

    localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

    state_t     state;
    logic       we_q;
    logic       err_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic [7:0] wait_cnt;
    logic [3:0] lat_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 8'd0;
            wdata_q  <= 8'd0;
            rdata_q  <= 8'd0;
            wait_cnt <= 8'd0;
            lat_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_req) begin
                        we_q     <= core_we;
                        addr_q   <= core_addr;
                        wdata_q  <= core_wdata;
                        wait_cnt <= 8'd0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // A grant on the timeout edge still wins.
                    if (arb_acq) begin
                        if (we_q) begin
                            state <= DONE;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= LAT;
                        end
                    end else if (wait_cnt == WAIT_LIM) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                LAT: begin
                    // Losing the grant restarts the latency wait but keeps the timeout budget.
                    if (!arb_acq) begin
                        state <= REQ;
                    end else if (lat_cnt == 4'd1) begin
                        rdata_q <= arb_dq;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_ready = (state == IDLE);
    assign core_done  = (state == DONE);
    assign core_err   = (state == DONE) && err_q;
    assign core_rdata = rdata_q;
    assign arb_rden   = ((state == REQ) || (state == LAT)) && !we_q;
    assign arb_wren   = (state == REQ) && we_q;
    assign arb_addr   = addr_q;
    assign arb_din    = wdata_q;

endmodule

// File: tb/tb_simd_core_port.sv
// Bench for simd_core_port: transaction-level model of grant runs and starved edges, plus directed literal checks.
module tb_simd_core_port;

    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       core_req = 1'b0;
    logic       core_we = 1'b0;
    logic [7:0] core_addr = 8'd0;
    logic [7:0] core_wdata = 8'd0;
    logic       core_ready, core_done, core_err;
    logic [7:0] core_rdata;
    logic       arb_rden, arb_wren;
    logic [7:0] arb_addr, arb_din;
    logic       arb_acq = 1'b0;
    logic [7:0] arb_dq = 8'd0;

    int errors = 0;
    int checks = 0;

    simd_core_port #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
        .arb_rden(arb_rden), .arb_wren(arb_wren), .arb_addr(arb_addr), .arb_din(arb_din),
        .arb_acq(arb_acq), .arb_dq(arb_dq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a transaction is either a store finishing on its first granted edge, or a load finishing
    // once RD_LAT+1 consecutive granted edges have been seen; ungranted edges that do not follow a
    // granted edge consume the timeout budget.
    bit         m_busy = 0, m_we = 0, m_done = 0, m_err = 0;
    int         m_run = 0, m_starve = 0;
    logic [7:0] m_addr = 8'd0, m_din = 8'd0, m_rdata = 8'd0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_we = 0; m_done = 0; m_err = 0; m_run = 0; m_starve = 0;
            m_addr = 8'd0; m_din = 8'd0; m_rdata = 8'd0;
        end else if (m_done) begin
            m_done = 0; m_err = 0;
        end else if (!m_busy) begin
            if (core_req) begin
                m_busy = 1; m_we = core_we; m_addr = core_addr; m_din = core_wdata;
                m_run = 0; m_starve = 0;
            end
        end else if (arb_acq) begin
            m_run++;
            if (m_we || m_run == RD_LAT + 1) begin
                if (!m_we) m_rdata = arb_dq;
                m_busy = 0; m_done = 1; m_err = 0;
            end
        end else begin
            if (m_run == 0) m_starve++;
            m_run = 0;
            if (m_starve == TIMEOUT) begin
                m_busy = 0; m_done = 1; m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", 8'(core_ready), 8'(!m_busy && !m_done));
        chk("done",  8'(core_done),  8'(m_done));
        chk("err",   8'(core_err),   8'(m_done && m_err));
        chk("rden",  8'(arb_rden),   8'(m_busy && !m_we));
        chk("wren",  8'(arb_wren),   8'(m_busy && m_we));
        chk("addr",  arb_addr, m_addr);
        chk("din",   arb_din,  m_din);
        chk("rdata", core_rdata, m_rdata);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        tick();
        core_req = 1'b0; core_addr = 8'($urandom); core_wdata = 8'($urandom);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", 8'(core_ready), 8'd1);
        chk("rst_done",  8'(core_done),  8'd0);
        chk("rst_rden",  8'(arb_rden),   8'd0);
        chk("rst_rdata", core_rdata,     8'd0);
        rstn = 1'b1;
        tick();

        // Store, grant on the third REQ edge
        issue(1'b1, 8'h10, 8'hA5);
        chk("st_wren", 8'(arb_wren), 8'd1);
        chk("st_ready", 8'(core_ready), 8'd0);
        tick(); tick();
        chk("st_hold_addr", arb_addr, 8'h10);
        chk("st_hold_din", arb_din, 8'hA5);
        arb_acq = 1'b1;
        tick();
        arb_acq = 1'b0;
        chk("st_wren_drop", 8'(arb_wren), 8'd0);
        chk("st_done", 8'(core_done), 8'd1);
        chk("st_err", 8'(core_err), 8'd0);
        tick();
        chk("st_done_once", 8'(core_done), 8'd0);
        chk("st_ready_back", 8'(core_ready), 8'd1);
        tick();

        // Load with held grant
        issue(1'b0, 8'h20, 8'h00);
        arb_acq = 1'b1; arb_dq = 8'h11;
        tick();
        chk("ld_rden_g", 8'(arb_rden), 8'd1);
        tick();
        chk("ld_rden_g1", 8'(arb_rden), 8'd1);
        chk("ld_nodone", 8'(core_done), 8'd0);
        arb_dq = 8'h3C;
        tick();
        arb_acq = 1'b0; arb_dq = 8'h55;
        chk("ld_done", 8'(core_done), 8'd1);
        chk("ld_rdata", core_rdata, 8'h3C);
        chk("ld_rden_drop", 8'(arb_rden), 8'd0);
        tick();
        chk("ld_done_once", 8'(core_done), 8'd0);
        tick();

        // Preempted load: grant lost after one LAT edge, back four edges later
        issue(1'b0, 8'h44, 8'h00);
        arb_acq = 1'b1; arb_dq = 8'h99;
        tick(); tick();
        arb_acq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pl_nodone", 8'(core_done), 8'd0);
        end
        arb_acq = 1'b1;
        tick(); tick();
        arb_dq = 8'h77;
        tick();
        arb_acq = 1'b0; arb_dq = 8'h00;
        chk("pl_done", 8'(core_done), 8'd1);
        chk("pl_err", 8'(core_err), 8'd0);
        chk("pl_rdata", core_rdata, 8'h77);
        tick();
        chk("pl_done_once", 8'(core_done), 8'd0);
        tick();

        // Timeout with no grant
        issue(1'b0, 8'h60, 8'h00);
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i < TIMEOUT) chk("to_early", 8'(core_done), 8'd0);
            tick();
        end
        chk("to_done", 8'(core_done), 8'd1);
        chk("to_err", 8'(core_err), 8'd1);
        chk("to_rden", 8'(arb_rden), 8'd0);
        chk("to_rdata", core_rdata, 8'h77);
        tick();
        chk("to_err_once", 8'(core_err), 8'd0);
        chk("to_rden_after", 8'(arb_rden), 8'd0);
        tick();

        // Reset during LAT, then a fresh store
        issue(1'b0, 8'h70, 8'h00);
        arb_acq = 1'b1;
        tick();
        rstn = 1'b0;
        #1;
        chk("rl_rden", 8'(arb_rden), 8'd0);
        chk("rl_ready", 8'(core_ready), 8'd1);
        chk("rl_rdata", core_rdata, 8'h00);
        arb_acq = 1'b0;
        tick();
        chk("rl_nodone", 8'(core_done), 8'd0);
        rstn = 1'b1;
        tick();
        issue(1'b1, 8'h33, 8'hC3);
        arb_acq = 1'b1;
        tick();
        arb_acq = 1'b0;
        chk("rl_new_done", 8'(core_done), 8'd1);
        chk("rl_new_din", arb_din, 8'hC3);
        tick();

        // Randomized traffic at several grant densities
        for (int blk = 0; blk < 6; blk++) begin
            int p;
            p = (blk == 0) ? 90 : (blk == 1) ? 60 : (blk == 2) ? 35 : (blk == 3) ? 15 : (blk == 4) ? 5 : 75;
            for (int c = 0; c < 500; c++) begin
                core_req   = ($urandom_range(1) == 1);
                core_we    = ($urandom_range(1) == 1);
                core_addr  = 8'($urandom);
                core_wdata = 8'($urandom);
                arb_acq    = ($urandom_range(99) < p);
                arb_dq     = 8'($urandom);
                rstn       = ($urandom_range(299) != 0);
                tick();
            end
        end
        rstn = 1'b1; core_req = 1'b0; arb_acq = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
